i2c_write_reg: RTL and testbench

Sequencer that writes a register address followed by 0–15 staged data bytes to an I2C slave (VL53L0X at 0x29 by default) through the shared I2C master. It is the write-side counterpart of the register read sequencer in the SensorModule. It stages payload bytes in a local buffer, issues one write-multiple command with stop, streams the bytes, and reports done or message_failure.

---
 rtl/i2c_seq_pkg.sv | 22 ++
 rtl/i2c_byte_buffer.sv | 63 ++++++
 rtl/i2c_write_reg.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_write_reg.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C register read/write sequencers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_seq_pkg;

    // Sequencer state encoding, also exported on state_out for debug.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CHECK_BUS = 4'd1,
        ST_CMD       = 4'd2,
        ST_SEND_REG  = 4'd3,
        ST_SEND_DATA = 4'd4,
        ST_WAIT_FREE = 4'd5,
        ST_DONE      = 4'd6,
        ST_FAIL      = 4'd7
    } seq_state_t;

    // 1 ms per wait at 27 MHz.
    localparam int         TIMEOUT_CYCLES_DEFAULT = 27000;
    localparam logic [6:0] VL53L0X_ADDR           = 7'h29;

endpackage

// File: rtl/i2c_byte_buffer.sv
// Byte staging FIFO with first-word fall-through head and a flush.
// Latency: push visible on head/count the cycle after; head_next is the entry behind head.
// Backpressure: pushes ignored when full, pops ignored when empty; flush wins over both.
// Ports: push/push_data, pop, flush in; head, head_next, count, full, empty out.
module i2c_byte_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               head,
    output logic [7:0]               head_next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign head      = r_mem[r_rd_ptr];
    // Lets a registered consumer load the following byte on the pop edge.
    assign head_next = r_mem[r_rd_ptr + AW'(1)];
    assign count     = r_count;
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);

endmodule

// File: rtl/i2c_write_reg.sv
// Writes a register address plus 0-15 staged bytes to an I2C slave via the shared master.
// Latency: busy the cycle after start; cmd_valid two cycles after start on an idle bus.
// Backpressure: cmd/data valids hold until ready; every wait times out to message_failure.
// Ports: staging load_* handshake, start/dev/reg/byte_width request, done/message_failure
// pulses, i2c_cmd_* and i2c_data_out_* towards the master, i2c_bus_* status from it.
module i2c_write_reg
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] dev_address,
    input  logic [7:0] reg_address,
    input  logic [3:0] byte_width,
    input  logic       start,
    input  logic [7:0] load_data,
    input  logic       load_valid,
    output logic       load_ready,
    output logic       done,
    output logic       message_failure,
    output logic       busy,
    output logic [6:0] i2c_dev_address,
    output logic       i2c_cmd_start,
    output logic       i2c_cmd_read,
    output logic       i2c_cmd_write,
    output logic       i2c_cmd_write_multiple,
    output logic       i2c_cmd_stop,
    output logic       i2c_cmd_valid,
    input  logic       i2c_cmd_ready,
    output logic [7:0] i2c_data_out,
    output logic       i2c_data_out_valid,
    input  logic       i2c_data_out_ready,
    output logic       i2c_data_out_last,
    input  logic       i2c_bus_busy,
    input  logic       i2c_bus_active,
    input  logic       i2c_bus_control,
    input  logic       i2c_missed_ack,
    output logic [3:0] state_out
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    seq_state_t    r_state;
    logic [7:0]    r_reg;
    logic [3:0]    r_bw;
    logic [3:0]    r_remaining;
    logic [TW-1:0] r_timer;
    logic          r_load_ready, r_done, r_fail, r_busy, r_cmd_valid;
    logic          r_dat_vld, r_dat_last;
    logic [7:0]    r_dat;
    logic [6:0]    r_dev;

    logic [7:0]    w_head, w_head_next;
    logic [CW-1:0] w_count, w_count_pushed;
    logic          w_full, w_empty, w_push, w_pop, w_flush;
    logic          w_in_wait, w_progress, w_timeout, w_go_fail;

    assign w_push         = load_valid && r_load_ready;
    assign w_pop          = (r_state == ST_SEND_DATA) && i2c_data_out_ready && !i2c_missed_ack && !w_empty;
    assign w_flush        = (r_state == ST_FAIL);
    assign w_count_pushed = w_count + CW'(w_push);

    i2c_byte_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (load_data),
        .pop       (w_pop),
        .flush     (w_flush),
        .head      (w_head),
        .head_next (w_head_next),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Per-state "the thing we are waiting for happened"; a handshake beats a timeout.
    always_comb begin
        w_progress = 1'b0;
        case (r_state)
            ST_CHECK_BUS: w_progress = !i2c_bus_busy && !i2c_bus_active;
            ST_CMD:       w_progress = i2c_cmd_ready;
            ST_SEND_REG,
            ST_SEND_DATA: w_progress = i2c_data_out_ready;
            ST_WAIT_FREE: w_progress = !i2c_bus_busy && !i2c_bus_control;
            default:      w_progress = 1'b0;
        endcase
    end

    assign w_in_wait = (r_state == ST_CHECK_BUS) || (r_state == ST_CMD) || (r_state == ST_SEND_REG) ||
                       (r_state == ST_SEND_DATA) || (r_state == ST_WAIT_FREE);
    assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));

    // DONE and FAIL are already terminal, so a late missed ack there is not a new failure.
    assign w_go_fail = (i2c_missed_ack && (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_FAIL)) ||
                       (w_in_wait && w_timeout && !w_progress) ||
                       ((r_state == ST_IDLE) && start && (w_count_pushed < CW'(byte_width)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_reg        <= '0;
            r_bw         <= '0;
            r_remaining  <= '0;
            r_timer      <= '0;
            r_load_ready <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_busy       <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_dat_vld    <= 1'b0;
            r_dat_last   <= 1'b0;
            r_dat        <= '0;
            r_dev        <= '0;
        end else begin
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            r_timer <= r_timer + TW'(1);
            if (w_go_fail) begin
                r_state      <= ST_FAIL;
                r_fail       <= 1'b1;
                r_busy       <= 1'b1;
                r_load_ready <= 1'b0;
                r_cmd_valid  <= 1'b0;
                r_dat_vld    <= 1'b0;
                r_dat_last   <= 1'b0;
                r_dat        <= '0;
                if (r_state == ST_IDLE) begin
                    r_dev <= dev_address;
                    r_reg <= reg_address;
                    r_bw  <= byte_width;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_load_ready <= (w_count_pushed != CW'(DEPTH));
                        if (start) begin
                            r_dev        <= dev_address;
                            r_reg        <= reg_address;
                            r_bw         <= byte_width;
                            r_busy       <= 1'b1;
                            r_load_ready <= 1'b0;
                            r_timer      <= '0;
                            r_state      <= ST_CHECK_BUS;
                        end
                    end
                    ST_CHECK_BUS: if (w_progress) begin
                        r_cmd_valid <= 1'b1;
                        r_timer     <= '0;
                        r_state     <= ST_CMD;
                    end
                    ST_CMD: if (w_progress) begin
                        r_cmd_valid <= 1'b0;
                        r_dat       <= r_reg;
                        r_dat_vld   <= 1'b1;
                        r_dat_last  <= (r_bw == 4'd0);
                        r_timer     <= '0;
                        r_state     <= ST_SEND_REG;
                    end
                    ST_SEND_REG: if (w_progress) begin
                        r_timer <= '0;
                        if (r_bw == 4'd0) begin
                            r_dat_vld  <= 1'b0;
                            r_dat_last <= 1'b0;
                            r_dat      <= '0;
                            r_state    <= ST_WAIT_FREE;
                        end else begin
                            r_dat       <= w_head;
                            r_dat_last  <= (r_bw == 4'd1);
                            r_remaining <= r_bw;
                            r_state     <= ST_SEND_DATA;
                        end
                    end
                    ST_SEND_DATA: if (w_progress) begin
                        r_timer <= '0;
                        if (r_remaining == 4'd1) begin
                            r_dat_vld  <= 1'b0;
                            r_dat_last <= 1'b0;
                            r_dat      <= '0;
                            r_state    <= ST_WAIT_FREE;
                        end else begin
                            r_dat       <= w_head_next;
                            r_dat_last  <= (r_remaining == 4'd2);
                            r_remaining <= r_remaining - 4'd1;
                        end
                    end
                    ST_WAIT_FREE: if (w_progress) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                    ST_DONE: begin
                        r_busy       <= 1'b0;
                        r_load_ready <= !w_full;
                        r_state      <= ST_IDLE;
                    end
                    ST_FAIL: begin
                        // Buffer is flushed this cycle, so it is empty on return to IDLE.
                        r_busy       <= 1'b0;
                        r_load_ready <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign load_ready             = r_load_ready;
    assign done                   = r_done;
    assign message_failure        = r_fail;
    assign busy                   = r_busy;
    assign i2c_dev_address        = r_dev;
    assign i2c_cmd_valid          = r_cmd_valid;
    assign i2c_cmd_start          = r_cmd_valid;
    assign i2c_cmd_write_multiple = r_cmd_valid;
    assign i2c_cmd_stop           = r_cmd_valid;
    assign i2c_cmd_read           = 1'b0;
    assign i2c_cmd_write          = 1'b0;
    assign i2c_data_out           = r_dat;
    assign i2c_data_out_valid     = r_dat_vld;
    assign i2c_data_out_last      = r_dat_last;
    assign state_out              = r_state;

endmodule

// File: tb/tb_i2c_write_reg.sv
// Directed bench for i2c_write_reg with a scoreboard of expected output bytes.
// Latency: n/a.
// Backpressure: bench plays the I2C master, holding ready low where needed.
module tb_i2c_write_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] dev_address = '0;
    logic [7:0] reg_address = '0;
    logic [3:0] byte_width = '0;
    logic       start = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_valid = 1'b0;
    logic       i2c_cmd_ready = 1'b0;
    logic       i2c_data_out_ready = 1'b0;
    logic       i2c_bus_busy = 1'b0;
    logic       i2c_bus_active = 1'b0;
    logic       i2c_bus_control = 1'b0;
    logic       i2c_missed_ack = 1'b0;

    logic       load_ready, done, message_failure, busy;
    logic [6:0] i2c_dev_address;
    logic       i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_write_multiple, i2c_cmd_stop, i2c_cmd_valid;
    logic [7:0] i2c_data_out;
    logic       i2c_data_out_valid, i2c_data_out_last;
    logic [3:0] state_out;

    always #5 clk = ~clk;

    i2c_write_reg #(.DEPTH(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .dev_address(dev_address), .reg_address(reg_address),
        .byte_width(byte_width), .start(start), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .done(done), .message_failure(message_failure), .busy(busy),
        .i2c_dev_address(i2c_dev_address), .i2c_cmd_start(i2c_cmd_start), .i2c_cmd_read(i2c_cmd_read),
        .i2c_cmd_write(i2c_cmd_write), .i2c_cmd_write_multiple(i2c_cmd_write_multiple),
        .i2c_cmd_stop(i2c_cmd_stop), .i2c_cmd_valid(i2c_cmd_valid), .i2c_cmd_ready(i2c_cmd_ready),
        .i2c_data_out(i2c_data_out), .i2c_data_out_valid(i2c_data_out_valid),
        .i2c_data_out_ready(i2c_data_out_ready), .i2c_data_out_last(i2c_data_out_last),
        .i2c_bus_busy(i2c_bus_busy), .i2c_bus_active(i2c_bus_active), .i2c_bus_control(i2c_bus_control),
        .i2c_missed_ack(i2c_missed_ack), .state_out(state_out)
    );

    typedef struct packed { logic [7:0] d; logic l; } exp_t;
    exp_t       q_exp[$];
    logic [7:0] q_stage[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic stage(input logic [7:0] b);
        check("stage_load_ready", load_ready, 1);
        load_valid = 1'b1;
        load_data  = b;
        q_stage.push_back(b);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Builds the expected stream (register address then staged bytes) as start is driven.
    task automatic start_txn(input logic [7:0] ra, input logic [3:0] bw);
        exp_t e;
        dev_address = 7'h29;
        reg_address = ra;
        byte_width  = bw;
        start       = 1'b1;
        q_exp.delete();
        e.d = ra; e.l = (bw == 4'd0);
        q_exp.push_back(e);
        for (int i = 0; i < int'(bw); i++) begin
            e.d = q_stage.pop_front();
            e.l = (i == int'(bw) - 1);
            q_exp.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("load_ready_while_busy", load_ready, 0);
    endtask

    task automatic fail_start(input string tag, input logic [3:0] bw);
        int w = 0;
        logic saw_cmd = 1'b0;
        reg_address = 8'h33;
        byte_width  = bw;
        start       = 1'b1;
        while (!message_failure && w < 2) begin
            @(negedge clk);
            start = 1'b0;
            w++;
            if (i2c_cmd_valid) saw_cmd = 1'b1;
        end
        start = 1'b0;
        check({tag, "_fail_pulse"}, message_failure, 1);
        check({tag, "_no_cmd"}, saw_cmd, 0);
        @(negedge clk);
        check({tag, "_fail_one_cycle"}, message_failure, 0);
        check({tag, "_idle"}, busy, 0);
        q_stage.delete();
    endtask

    task automatic serve_cmd();
        int w = 0;
        while (!i2c_cmd_valid && w < 20) begin @(negedge clk); w++; end
        check("cmd_valid", i2c_cmd_valid, 1);
        check("cmd_flags", {i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_write_multiple, i2c_cmd_stop}, 5'b10011);
        check("cmd_dev", i2c_dev_address, 7'h29);
        i2c_cmd_ready = 1'b1;
        @(negedge clk);
        i2c_cmd_ready = 1'b0;
        check("cmd_valid_drop", i2c_cmd_valid, 0);
    endtask

    task automatic serve_bytes(input int n, input int hold);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (!i2c_data_out_valid && w < 20) begin @(negedge clk); w++; end
            repeat (hold) @(negedge clk);
            check("data_valid", i2c_data_out_valid, 1);
            e = q_exp.pop_front();
            check("data_byte", i2c_data_out, e.d);
            check("data_last", i2c_data_out_last, e.l);
            i2c_data_out_ready = 1'b1;
            @(negedge clk);
            i2c_data_out_ready = 1'b0;
        end
    endtask

    task automatic wait_done();
        int w = 0;
        logic saw_fail = 1'b0;
        while (!done && w < 20) begin
            @(negedge clk);
            w++;
            if (message_failure) saw_fail = 1'b1;
        end
        check("done_pulse", done, 1);
        check("no_failure_on_success", saw_fail, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        int   cyc;
        logic held;

        // Reset state
        @(negedge clk);
        check("rst_outputs", {load_ready, done, message_failure, busy, i2c_cmd_valid, i2c_data_out_valid,
                              i2c_data_out_last, i2c_cmd_start, i2c_cmd_stop}, 9'h0);
        check("rst_dev", i2c_dev_address, 0);
        check("rst_state", state_out, 0);
        reset = 1'b1;
        @(negedge clk);
        check("load_ready_after_rst", load_ready, 1);

        // Two-byte write with a slow data consumer
        stage(8'hA1);
        stage(8'hB2);
        start_txn(8'h8A, 4'd2);
        check("cmd_not_yet", i2c_cmd_valid, 0);
        @(negedge clk);
        check("cmd_at_n_plus_2", i2c_cmd_valid, 1);
        serve_cmd();
        serve_bytes(3, 2);
        wait_done();

        // Register-pointer-only write keeps the staged byte for the next transfer
        stage(8'h5C);
        start_txn(8'h91, 4'd0);
        serve_cmd();
        serve_bytes(1, 0);
        wait_done();
        start_txn(8'h10, 4'd1);
        serve_cmd();
        serve_bytes(2, 0);
        wait_done();

        // Byte pushed in the same cycle as start counts towards byte_width
        load_valid = 1'b1;
        load_data  = 8'h3E;
        q_stage.push_back(8'h3E);
        start_txn(8'h20, 4'd1);
        load_valid = 1'b0;
        serve_cmd();
        serve_bytes(2, 0);
        wait_done();

        // Too few staged bytes: immediate failure, then buffer shown empty
        stage(8'h77);
        fail_start("short", 4'd3);
        fail_start("flushed_short", 4'd1);

        // Missed ack after the first data byte
        stage(8'h11);
        stage(8'h22);
        stage(8'h33);
        start_txn(8'h40, 4'd3);
        serve_cmd();
        serve_bytes(2, 0);
        i2c_missed_ack = 1'b1;
        @(negedge clk);
        i2c_missed_ack = 1'b0;
        check("nack_fail_pulse", message_failure, 1);
        check("nack_data_drop", i2c_data_out_valid, 0);
        @(negedge clk);
        check("nack_idle", busy, 0);
        check("nack_load_ready", load_ready, 1);
        q_exp.delete();
        fail_start("flushed_nack", 4'd1);

        // Data ready held low: failure 100 cycles after SEND_REG entry
        start_txn(8'h55, 4'd0);
        serve_cmd();
        cyc = 0;
        held = 1'b1;
        while (!message_failure && cyc < 200) begin
            if (!i2c_data_out_valid || i2c_data_out !== 8'h55) held = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("data_timeout_cycles", cyc, 100);
        check("data_held_until_timeout", held, 1);
        @(negedge clk);
        check("data_timeout_idle", busy, 0);
        q_exp.delete();

        // Bus busy held high: same timeout from CHECK_BUS entry
        i2c_bus_busy = 1'b1;
        start_txn(8'h56, 4'd0);
        cyc = 0;
        held = 1'b1;
        while (!message_failure && cyc < 200) begin
            if (i2c_cmd_valid) held = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("bus_timeout_cycles", cyc, 100);
        check("bus_timeout_no_cmd", held, 1);
        i2c_bus_busy = 1'b0;
        @(negedge clk);
        check("bus_timeout_idle", busy, 0);
        q_exp.delete();

        // Reset asserted mid SEND_DATA
        stage(8'hAA);
        stage(8'hBB);
        start_txn(8'h60, 4'd2);
        serve_cmd();
        serve_bytes(1, 0);
        check("pre_reset_send_data", state_out, 4);
        reset = 1'b0;
        #1;
        check("async_rst_outputs", {load_ready, done, message_failure, busy, i2c_cmd_valid, i2c_data_out_valid,
                                    i2c_data_out_last}, 7'h0);
        check("async_rst_data", i2c_data_out, 0);
        check("async_rst_dev", i2c_dev_address, 0);
        check("async_rst_state", state_out, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_state", state_out, 0);
        check("post_rst_load_ready", load_ready, 1);
        q_exp.delete();
        q_stage.delete();
        fail_start("flushed_rst", 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
